// File: rtl/wash_phase_ctrl.sv
// Washing-machine phase sequencer: wash/rinse/dry with weight-scaled
// durations, pause/resume, remaining-time tracking and phase-end pulses.
module wash_phase_ctrl #(
  parameter int WASH_UNIT  = 3,
  parameter int RINSE_UNIT = 2,
  parameter int DRY_UNIT   = 1,
  parameter int TIME_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power,
  input  logic              start_pause,
  input  logic              sec_tick,
  input  logic [2:0]        mode,
  input  logic [2:0]        weight,
  output logic [2:0]        phase,
  output logic              running,
  output logic              paused,
  output logic              done,
  output logic [TIME_W-1:0] remain_time,
  output logic [2:0]        w_r_d_end
);

  typedef enum logic [2:0] {
    S_IDLE, S_WASH, S_RINSE, S_DRY, S_PAUSE, S_DONE
  } state_t;

  state_t state, nxt_state;
  state_t hold, nxt_hold;

  logic [TIME_W-1:0] cnt, nxt_cnt, nxt_remain;
  logic [2:0] mode_l, nxt_mode;
  logic [2:0] w_l, nxt_w;
  logic [2:0] nxt_end;
  logic [2:0] wn, first, nx_ph;
  logic [TIME_W-1:0] total;

  // Highest-priority enabled phase, order wash > rinse > dry.
  function automatic logic [2:0] pick(input logic [2:0] m);
    logic [2:0] p;
    p = 3'b000;
    if (m[2])      p = 3'b100;
    else if (m[1]) p = 3'b010;
    else if (m[0]) p = 3'b001;
    return p;
  endfunction

  function automatic logic [TIME_W-1:0] dur(
    input logic [2:0] p,
    input logic [2:0] w
  );
    logic [TIME_W-1:0] d;
    d = '0;
    unique case (1'b1)
      p[2]:    d = TIME_W'(w) * TIME_W'(WASH_UNIT);
      p[1]:    d = TIME_W'(w) * TIME_W'(RINSE_UNIT);
      p[0]:    d = TIME_W'(w) * TIME_W'(DRY_UNIT);
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic state_t st_of(input logic [2:0] p);
    state_t s;
    s = S_DONE;
    unique case (1'b1)
      p[2]:    s = S_WASH;
      p[1]:    s = S_RINSE;
      p[0]:    s = S_DRY;
      default: s = S_DONE;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] oh_of(input state_t s);
    logic [2:0] p;
    p = 3'b000;
    unique case (s)
      S_WASH:  p = 3'b100;
      S_RINSE: p = 3'b010;
      S_DRY:   p = 3'b001;
      default: p = 3'b000;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] later(input state_t s);
    logic [2:0] m;
    m = 3'b000;
    unique case (s)
      S_WASH:  m = 3'b011;
      S_RINSE: m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  always_comb begin
    nxt_state  = state;
    nxt_hold   = hold;
    nxt_cnt    = cnt;
    nxt_remain = remain_time;
    nxt_mode   = mode_l;
    nxt_w      = w_l;
    nxt_end    = 3'b000;
    wn    = (weight == 3'd0) ? 3'd1 : weight;
    first = pick(mode);
    nx_ph = pick(mode_l & later(state));
    total = dur(mode & 3'b100, wn)
          + dur(mode & 3'b010, wn)
          + dur(mode & 3'b001, wn);
    if (!power) begin
      nxt_state  = S_IDLE;
      nxt_hold   = S_IDLE;
      nxt_cnt    = '0;
      nxt_remain = '0;
      nxt_mode   = 3'b000;
      nxt_w      = 3'b000;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_pause && mode != 3'b000) begin
            nxt_mode   = mode;
            nxt_w      = wn;
            nxt_state  = st_of(first);
            nxt_cnt    = dur(first, wn);
            nxt_remain = total;
          end
        end
        S_WASH, S_RINSE, S_DRY: begin
          // Pause is checked first so a coincident tick is dropped.
          if (start_pause) begin
            nxt_state = S_PAUSE;
            nxt_hold  = state;
          end else if (sec_tick) begin
            nxt_remain = remain_time - 1'b1;
            if (cnt == TIME_W'(1)) begin
              nxt_end   = oh_of(state);
              nxt_state = st_of(nx_ph);
              nxt_cnt   = dur(nx_ph, w_l);
              if (nx_ph == 3'b000) nxt_remain = '0;
            end else begin
              nxt_cnt = cnt - 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (start_pause) nxt_state = hold;
        end
        S_DONE: begin
          if (start_pause) begin
            nxt_state = S_IDLE;
            nxt_mode  = 3'b000;
            nxt_w     = 3'b000;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hold        <= S_IDLE;
      cnt         <= '0;
      remain_time <= '0;
      mode_l      <= 3'b000;
      w_l         <= 3'b000;
      phase       <= 3'b000;
      running     <= 1'b0;
      paused      <= 1'b0;
      done        <= 1'b0;
      w_r_d_end   <= 3'b000;
    end else begin
      state       <= nxt_state;
      hold        <= nxt_hold;
      cnt         <= nxt_cnt;
      remain_time <= nxt_remain;
      mode_l      <= nxt_mode;
      w_l         <= nxt_w;
      phase       <= oh_of((nxt_state == S_PAUSE) ? nxt_hold : nxt_state);
      running     <= (nxt_state == S_WASH) || (nxt_state == S_RINSE)
                  || (nxt_state == S_DRY);
      paused      <= (nxt_state == S_PAUSE);
      done        <= (nxt_state == S_DONE);
      w_r_d_end   <= nxt_end;
    end
  end

endmodule
